// File: rtl/pcm_peak_pkg.sv
// ---------------------------------------------------------------------------
// pcm_peak_pkg
//   Shared types and helpers for the PCM peak detectors.
//   - ch_state_t : per-channel detector state
//   - pcm_mag()  : two's-complement magnitude with saturation of the most
//                  negative code, so |x| always fits in the sample width
// ---------------------------------------------------------------------------
package pcm_peak_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        TRACK = 2'd2,
        DONE  = 2'd3
    } ch_state_t;

    // Width-generic magnitude. The caller sign-extends its sample to 64 bits,
    // passes the true sample width w and keeps the low w bits of the result.
    // The most negative w-bit code has no positive twin and is clamped to
    // 2^(w-1)-1.
    function automatic logic [63:0] pcm_mag(input logic signed [63:0] x,
                                            input int unsigned        w);
        logic [63:0] max_pos;
        logic [63:0] most_neg;
        logic [63:0] result;
        max_pos  = (64'd1 << (w - 1)) - 64'd1;
        most_neg = ~max_pos;
        if (!x[63]) begin
            result = x;
        end else if (x == most_neg) begin
            result = max_pos;
        end else begin
            result = -x;
        end
        return result;
    endfunction

endpackage

// File: rtl/pcm_peak_channel.sv
// ---------------------------------------------------------------------------
// pcm_peak_channel
//   One detector channel: arms on command, triggers on the first magnitude
//   above threshold, then tracks the maximum and its timestamp for WINDOW
//   samples (trigger sample included) before parking in DONE.
// Ports
//   pcm_clk, reset_n  clock, synchronous active-low reset
//   arm               restart pulse (wins over a same-cycle sample)
//   pcm_valid         sample strobe
//   sample            signed PCM sample for this channel
//   sample_counter    timestamp of the current sample
//   threshold         unsigned trigger level
//   trig              this cycle's sample fires the trigger (combinational)
//   done              window complete
//   peak, peak_time   tracked maximum and its timestamp
// ---------------------------------------------------------------------------
module pcm_peak_channel
    import pcm_peak_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int TIME_W   = 32,
    parameter int WINDOW   = 1024,
    parameter bit ABS_MODE = 1'b1
) (
    input  logic                     pcm_clk,
    input  logic                     reset_n,
    input  logic                     arm,
    input  logic                     pcm_valid,
    input  logic signed [DATA_W-1:0] sample,
    input  logic        [TIME_W-1:0] sample_counter,
    input  logic        [DATA_W-1:0] threshold,
    output logic                     trig,
    output logic                     done,
    output logic        [DATA_W-1:0] peak,
    output logic        [TIME_W-1:0] peak_time
);

    localparam int CNT_W = $clog2(WINDOW + 1);
    localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WINDOW);

    ch_state_t        state;
    ch_state_t        state_next;
    logic [CNT_W-1:0] win_cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             track_step;
    logic             peak_upd;

    // All compares run one bit wider and signed: in ABS_MODE the magnitude is
    // zero-extended, otherwise the raw sample is sign-extended so negative
    // samples sit below every (non-negative) threshold and peak.
    logic signed [DATA_W:0] mag_ext;
    logic signed [DATA_W:0] thr_ext;
    logic signed [DATA_W:0] peak_ext;

    always_comb begin
        if (ABS_MODE) begin
            mag_ext = {1'b0, DATA_W'(pcm_mag(64'(sample), 32'(DATA_W)))};
        end else begin
            mag_ext = {sample[DATA_W-1], sample};
        end
    end

    assign thr_ext  = {1'b0, threshold};
    assign peak_ext = {1'b0, peak};
    assign cnt_inc  = win_cnt + CNT_W'(1);
    assign done     = (state == DONE);

    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        trig       = 1'b0;
        track_step = 1'b0;
        peak_upd   = 1'b0;
        if (arm) begin
            state_next = ARMED;
        end else if (pcm_valid) begin
            unique case (state)
                ARMED: begin
                    if (mag_ext > thr_ext) begin
                        trig       = 1'b1;
                        state_next = (WINDOW == 1) ? DONE : TRACK;
                    end
                end
                TRACK: begin
                    track_step = 1'b1;
                    peak_upd   = (mag_ext > peak_ext);   // strict: ties keep earliest
                    if (cnt_inc == WIN_LAST) begin
                        state_next = DONE;
                    end
                end
                default: ;   // IDLE and DONE ignore samples
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge pcm_clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge pcm_clk) begin
        if (!reset_n) begin
            peak      <= '0;
            peak_time <= '0;
            win_cnt   <= '0;
        end else if (arm) begin
            peak      <= '0;
            peak_time <= '0;
            win_cnt   <= '0;
        end else if (trig) begin
            peak      <= mag_ext[DATA_W-1:0];
            peak_time <= sample_counter;
            win_cnt   <= CNT_W'(1);
        end else if (track_step) begin
            win_cnt <= cnt_inc;
            if (peak_upd) begin
                peak      <= mag_ext[DATA_W-1:0];
                peak_time <= sample_counter;
            end
        end
    end

endmodule

// File: rtl/pcm_multi_peak_detector.sv
// ---------------------------------------------------------------------------
// pcm_multi_peak_detector
//   NUM_CH parallel PCM threshold/peak detectors for mic-array localisation.
//   Reports per-channel completion, the earliest-triggering channel and a
//   readout mux of each channel's peak magnitude and timestamp.
// Ports
//   pcm_clk, reset_n   clock, synchronous active-low reset
//   pcm_valid          sample strobe for pcm_data / sample_counter
//   pcm_data           packed signed samples, ch0 in the LSBs
//   sample_counter     timestamp of the current sample
//   threshold          unsigned trigger level
//   arm                restart all channels
//   ch_done, all_done  per-channel / global window completion
//   first_valid        first_ch holds a result
//   first_ch           earliest triggering channel (lowest index on ties)
//   rd_ch              readout select
//   rd_peak, rd_time   peak and its timestamp for rd_ch
// ---------------------------------------------------------------------------
module pcm_multi_peak_detector
    import pcm_peak_pkg::*;
#(
    parameter  int DATA_W   = 16,
    parameter  int TIME_W   = 32,
    parameter  int NUM_CH   = 4,
    parameter  int WINDOW   = 1024,
    parameter  bit ABS_MODE = 1'b1,
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     pcm_clk,
    input  logic                     reset_n,
    input  logic                     pcm_valid,
    input  logic [NUM_CH*DATA_W-1:0] pcm_data,
    input  logic [TIME_W-1:0]        sample_counter,
    input  logic [DATA_W-1:0]        threshold,
    input  logic                     arm,
    output logic [NUM_CH-1:0]        ch_done,
    output logic                     all_done,
    output logic                     first_valid,
    output logic [CH_W-1:0]          first_ch,
    input  logic [CH_W-1:0]          rd_ch,
    output logic [DATA_W-1:0]        rd_peak,
    output logic [TIME_W-1:0]        rd_time
);

    logic [NUM_CH-1:0] trig;
    logic [DATA_W-1:0] peak_arr [NUM_CH];
    logic [TIME_W-1:0] time_arr [NUM_CH];
    logic [CH_W-1:0]   first_sel;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        pcm_peak_channel #(
            .DATA_W   (DATA_W),
            .TIME_W   (TIME_W),
            .WINDOW   (WINDOW),
            .ABS_MODE (ABS_MODE)
        ) u_ch (
            .pcm_clk        (pcm_clk),
            .reset_n        (reset_n),
            .arm            (arm),
            .pcm_valid      (pcm_valid),
            .sample         (pcm_data[i*DATA_W +: DATA_W]),
            .sample_counter (sample_counter),
            .threshold      (threshold),
            .trig           (trig[i]),
            .done           (ch_done[i]),
            .peak           (peak_arr[i]),
            .peak_time      (time_arr[i])
        );
    end

    assign all_done = &ch_done;

    // Priority encoder: scanning downwards leaves the lowest triggering index.
    always_comb begin
        first_sel = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (trig[i]) begin
                first_sel = CH_W'(i);
            end
        end
    end

    // trig is already qualified by pcm_valid and suppressed by arm inside
    // each channel, so only the first-capture condition is needed here.
    always_ff @(posedge pcm_clk) begin
        if (!reset_n) begin
            first_valid <= 1'b0;
            first_ch    <= '0;
        end else if (arm) begin
            first_valid <= 1'b0;
            first_ch    <= '0;
        end else if (!first_valid && (|trig)) begin
            first_valid <= 1'b1;
            first_ch    <= first_sel;
        end
    end

    // Out-of-range selects (NUM_CH not a power of two) read as zero.
    always_comb begin
        rd_peak = '0;
        rd_time = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_ch == CH_W'(i)) begin
                rd_peak = peak_arr[i];
                rd_time = time_arr[i];
            end
        end
    end

endmodule

// File: tb/tb_pcm_multi_peak_detector.sv
// ---------------------------------------------------------------------------
// tb_pcm_multi_peak_detector
//   Directed test of pcm_multi_peak_detector with WINDOW=8, ABS_MODE=1.
// ---------------------------------------------------------------------------
module tb_pcm_multi_peak_detector;

    localparam int DATA_W = 16;
    localparam int TIME_W = 32;
    localparam int NUM_CH = 4;
    localparam int WINDOW = 8;
    localparam int CH_W   = 2;

    logic                     pcm_clk;
    logic                     reset_n;
    logic                     pcm_valid;
    logic [NUM_CH*DATA_W-1:0] pcm_data;
    logic [TIME_W-1:0]        sample_counter;
    logic [DATA_W-1:0]        threshold;
    logic                     arm;
    logic [NUM_CH-1:0]        ch_done;
    logic                     all_done;
    logic                     first_valid;
    logic [CH_W-1:0]          first_ch;
    logic [CH_W-1:0]          rd_ch;
    logic [DATA_W-1:0]        rd_peak;
    logic [TIME_W-1:0]        rd_time;

    int n_cmp = 0;
    int n_bad = 0;

    pcm_multi_peak_detector #(
        .DATA_W   (DATA_W),
        .TIME_W   (TIME_W),
        .NUM_CH   (NUM_CH),
        .WINDOW   (WINDOW),
        .ABS_MODE (1'b1)
    ) dut (
        .pcm_clk        (pcm_clk),
        .reset_n        (reset_n),
        .pcm_valid      (pcm_valid),
        .pcm_data       (pcm_data),
        .sample_counter (sample_counter),
        .threshold      (threshold),
        .arm            (arm),
        .ch_done        (ch_done),
        .all_done       (all_done),
        .first_valid    (first_valid),
        .first_ch       (first_ch),
        .rd_ch          (rd_ch),
        .rd_peak        (rd_peak),
        .rd_time        (rd_time)
    );

    initial pcm_clk = 1'b0;
    always #5 pcm_clk = ~pcm_clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [NUM_CH*DATA_W-1:0] pack(input int c0, input int c1,
                                                      input int c2, input int c3);
        return {DATA_W'(c3), DATA_W'(c2), DATA_W'(c1), DATA_W'(c0)};
    endfunction

    // One valid sample; outputs are stable on return (1 time unit after the edge).
    task automatic sample(input int c0, input int c1, input int c2, input int c3, input int t);
        @(negedge pcm_clk);
        pcm_data       = pack(c0, c1, c2, c3);
        sample_counter = TIME_W'(t);
        pcm_valid      = 1'b1;
        @(posedge pcm_clk);
        #1;
        pcm_valid = 1'b0;
    endtask

    task automatic do_arm();
        @(negedge pcm_clk);
        arm = 1'b1;
        @(posedge pcm_clk);
        #1;
        arm = 1'b0;
    endtask

    task automatic read(input int ch);
        rd_ch = CH_W'(ch);
        #1;
    endtask

    initial begin
        reset_n        = 1'b0;
        pcm_valid      = 1'b0;
        pcm_data       = '0;
        sample_counter = '0;
        threshold      = 16'd150;
        arm            = 1'b0;
        rd_ch          = '0;
        repeat (3) @(posedge pcm_clk);
        #1;

        // ---- 1: reset state, no arm -> nothing triggers ----
        check("rst_ch_done", 64'(ch_done), 64'd0);
        check("rst_all_done", 64'(all_done), 64'd0);
        check("rst_first_valid", 64'(first_valid), 64'd0);
        @(negedge pcm_clk);
        reset_n = 1'b1;
        sample(1000, 0, 0, 0, 1);
        check("idle_ch_done", 64'(ch_done), 64'd0);
        check("idle_first_valid", 64'(first_valid), 64'd0);
        read(0);
        check("idle_rd_peak", 64'(rd_peak), 64'd0);
        check("idle_rd_time", 64'(rd_time), 64'd0);

        // ---- 2: single channel track, window of 8 from t=11 ----
        threshold = 16'd150;
        do_arm();
        begin
            int ch1_seq [9] = '{100, 200, 500, 300, 100, 100, 100, 100, 100};
            for (int k = 0; k < 9; k++) begin
                sample(0, ch1_seq[k], 0, 0, 10 + k);
                if (k == 1) begin
                    check("t2_first_valid", 64'(first_valid), 64'd1);
                    check("t2_first_ch", 64'(first_ch), 64'd1);
                end
                if (k == 7) check("t2_not_done_t17", 64'(ch_done), 64'd0);
                if (k == 8) check("t2_done_t18", 64'(ch_done), 64'b0010);
            end
        end
        read(1);
        check("t2_peak", 64'(rd_peak), 64'd500);
        check("t2_time", 64'(rd_time), 64'd12);
        sample(0, 1000, 0, 0, 19);   // DONE holds its results
        read(1);
        check("t2_hold_peak", 64'(rd_peak), 64'd500);
        read(0);
        check("t2_ch0_peak", 64'(rd_peak), 64'd0);

        // ---- 3: simultaneous first triggers, staggered windows ----
        do_arm();
        check("t3_arm_clears", 64'(ch_done), 64'd0);
        sample(10, 10, 200, 300, 40);
        check("t3_first_valid", 64'(first_valid), 64'd1);
        check("t3_first_ch", 64'(first_ch), 64'd2);
        sample(400, 10, 10, 10, 41);
        check("t3_first_ch_hold", 64'(first_ch), 64'd2);
        sample(10, 160, 10, 10, 42);
        for (int t = 43; t <= 49; t++) begin
            sample(10, 10, 10, 10, t);
            if (t == 47) check("t3_done_t47", 64'(ch_done), 64'b1100);
            if (t == 48) begin
                check("t3_done_t48", 64'(ch_done), 64'b1101);
                check("t3_all_done_t48", 64'(all_done), 64'd0);
            end
            if (t == 49) check("t3_all_done_t49", 64'(all_done), 64'd1);
        end
        read(0); check("t3_peak0", 64'(rd_peak), 64'd400); check("t3_time0", 64'(rd_time), 64'd41);
        read(1); check("t3_peak1", 64'(rd_peak), 64'd160); check("t3_time1", 64'(rd_time), 64'd42);
        read(2); check("t3_peak2", 64'(rd_peak), 64'd200); check("t3_time2", 64'(rd_time), 64'd40);
        read(3); check("t3_peak3", 64'(rd_peak), 64'd300); check("t3_time3", 64'(rd_time), 64'd40);

        // ---- 4: magnitude saturation and tie handling ----
        threshold = 16'd1000;
        do_arm();
        sample(-32768, -500, 0, 0, 100);
        check("t4_first_ch", 64'(first_ch), 64'd0);
        read(0);
        check("t4_sat_peak", 64'(rd_peak), 64'd32767);
        sample(32767, -2000, 0, 0, 101);
        sample(-32767, 0, 0, 0, 102);
        read(0);
        check("t4_tie_peak", 64'(rd_peak), 64'd32767);
        check("t4_tie_time", 64'(rd_time), 64'd100);
        read(1);
        check("t4_neg_peak", 64'(rd_peak), 64'd2000);
        check("t4_neg_time", 64'(rd_time), 64'd101);

        // ---- 5: control corners ----
        threshold = 16'd150;
        @(negedge pcm_clk);          // arm with a crossing sample: sample dropped
        arm            = 1'b1;
        pcm_valid      = 1'b1;
        pcm_data       = pack(0, 0, 0, 5000);
        sample_counter = 32'd200;
        @(posedge pcm_clk);
        #1;
        arm       = 1'b0;
        pcm_valid = 1'b0;
        check("t5_arm_drop_fv", 64'(first_valid), 64'd0);
        read(3);
        check("t5_arm_drop_peak", 64'(rd_peak), 64'd0);
        sample(0, 0, 0, 100, 201);
        check("t5_below_thr_fv", 64'(first_valid), 64'd0);
        sample(0, 0, 0, 200, 202);
        check("t5_trig_first_ch", 64'(first_ch), 64'd3);
        read(3);
        check("t5_trig_peak", 64'(rd_peak), 64'd200);
        check("t5_trig_time", 64'(rd_time), 64'd202);
        @(negedge pcm_clk);          // valid low: large data must be ignored
        pcm_data       = pack(9000, 9000, 9000, 9000);
        sample_counter = 32'd300;
        repeat (5) @(posedge pcm_clk);
        #1;
        check("t5_novalid_peak", 64'(rd_peak), 64'd200);
        check("t5_novalid_time", 64'(rd_time), 64'd202);
        check("t5_novalid_done", 64'(ch_done), 64'd0);
        @(negedge pcm_clk);          // reset mid-TRACK, with a competing arm
        reset_n = 1'b0;
        arm     = 1'b1;
        @(posedge pcm_clk);
        #1;
        check("t5_rst_first_valid", 64'(first_valid), 64'd0);
        check("t5_rst_first_ch", 64'(first_ch), 64'd0);
        check("t5_rst_peak", 64'(rd_peak), 64'd0);
        check("t5_rst_time", 64'(rd_time), 64'd0);
        check("t5_rst_done", 64'(ch_done), 64'd0);
        @(negedge pcm_clk);
        reset_n = 1'b1;
        arm     = 1'b0;
        sample(0, 0, 0, 5000, 400);  // channels are IDLE after reset, so no trigger
        check("t5_post_rst_idle", 64'(first_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
